// File: rtl/intirvx_imem_axi_rd_if.sv
// AXI5 channel payload types and the axi5 interface used by the instruction-memory read responder.
package intirvx_imem_axi_rd_pkg;
    localparam int unsigned AXI_AW  = 32;
    localparam int unsigned AXI_IDW = 4;
    localparam int unsigned AXI_LW  = 8;
    localparam int unsigned XLEN    = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_S16    = 3'b001;
    localparam logic [2:0] SIZE_S32    = 3'b010;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [AXI_AW-1:0]  addr;
        logic [AXI_LW-1:0]  len;
        logic [2:0]         size;
        logic [1:0]         burst;
    } ax_t;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [XLEN-1:0]    data;
        logic [1:0]         resp;
        logic               last;
    } r_t;

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [AXI_IDW-1:0] id;
        logic [1:0]         resp;
    } b_t;
endpackage

interface axi5;
    import intirvx_imem_axi_rd_pkg::*;

    logic ar_valid;
    logic ar_ready;
    ax_t  ar;
    logic r_valid;
    logic r_ready;
    r_t   r;
    logic aw_valid;
    logic aw_ready;
    ax_t  aw;
    logic w_valid;
    logic w_ready;
    w_t   w;
    logic b_valid;
    logic b_ready;
    b_t   b;

    modport slave (
        input  ar_valid, ar, r_ready, aw_valid, aw, w_valid, w, b_ready,
        output ar_ready, r_valid, r, aw_ready, w_ready, b_valid, b
    );

    modport master (
        output ar_valid, ar, r_ready, aw_valid, aw, w_valid, w, b_ready,
        input  ar_ready, r_valid, r, aw_ready, w_ready, b_valid, b
    );
endinterface

// File: rtl/intirvx_imem_axi_rd.sv
// AXI5 read responder in front of a synchronous-read instruction SRAM.
// One burst at a time, up to 1 R beat/cycle, at most 2 beats in flight.
// Optional write-channel error responder enabled by macro IMEM_AXI_WR_ERR_EN.
module intirvx_imem_axi_rd
    import intirvx_imem_axi_rd_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned MEM_AW    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    axi5.slave                axi,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam logic [AXI_AW:0] MEM_BYTES = (AXI_AW+1)'(MEM_WORDS * 4);

    typedef enum logic [1:0] {IDLE, BURST, WDATA, WRESP} state_t;

    // Output buffer entry; pend marks data still arriving on mem_rdata this cycle.
    typedef struct packed {
        logic            pend;
        logic            last;
        logic [1:0]      resp;
        logic [XLEN-1:0] data;
    } ent_t;

    state_t              state, state_n;
    logic                rdy_q;
    logic [AXI_LW-1:0]   len_q;
    logic [AXI_IDW-1:0]  id_q;
    logic                fixed_q, err_req_q;
    logic [AXI_AW-1:0]   addr_q;
    logic [AXI_LW:0]     beat_cnt;
    logic                s1_v, s1_err, s1_last;
    ent_t                f0, f1, f0_n, f1_n, s1_ent;
    logic [1:0]          cnt, cnt_n;
    logic                r_valid_q;

    logic                ar_hs, pop, credit, issue, iss_err, iss_last, iss_fixed, iss_req_err, ar_err;
    logic [2:0]          occ;
    logic [AXI_AW-1:0]   iss_addr;

    // Beat issue: first beat straight from the AR handshake, later beats from the burst counters.
    always_comb begin
        ar_hs       = axi.ar_valid && rdy_q && (state == IDLE);
        pop         = r_valid_q && axi.r_ready;
        occ         = 3'(cnt) + 3'(s1_v) - 3'(pop);
        credit      = (occ < 3'd2);
        ar_err      = (axi.ar.size != SIZE_S32) ||
                      !((axi.ar.burst == BURST_FIXED) || (axi.ar.burst == BURST_INCR));
        issue       = 1'b0;
        iss_addr    = addr_q;
        iss_req_err = err_req_q;
        iss_last    = (beat_cnt[AXI_LW-1:0] == len_q);
        iss_fixed   = fixed_q;
        if (ar_hs) begin
            issue       = 1'b1;
            iss_addr    = {axi.ar.addr[AXI_AW-1:2], 2'b00};
            iss_req_err = ar_err;
            iss_last    = (axi.ar.len == '0);
            iss_fixed   = (axi.ar.burst == BURST_FIXED);
        end else if ((state == BURST) && (beat_cnt <= {1'b0, len_q}) && credit) begin
            issue = 1'b1;
        end
        iss_err = iss_req_err || ({1'b0, iss_addr} >= MEM_BYTES);
    end

`ifdef IMEM_AXI_WR_ERR_EN
    logic               aw_hs, w_hs, b_hs, w_ready_q, b_valid_q;
    logic [AXI_IDW-1:0] wid_q;

    assign axi.aw_ready = rdy_q && !axi.ar_valid;
    assign axi.w_ready  = w_ready_q;
    assign axi.b_valid  = b_valid_q;
    assign axi.b        = {wid_q, RESP_SLVERR};
    assign aw_hs        = axi.aw_valid && axi.aw_ready && (state == IDLE);
    assign w_hs         = axi.w_valid && w_ready_q;
    assign b_hs         = b_valid_q && axi.b_ready;

    // Write error responder: latch AW id, raise w_ready / b_valid from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wid_q     <= '0;
            w_ready_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            if (aw_hs) wid_q <= axi.aw.id;
            w_ready_q <= (state_n == WDATA);
            b_valid_q <= (state_n == WRESP);
        end
    end
`else
    assign axi.aw_ready = 1'b0;
    assign axi.w_ready  = 1'b0;
    assign axi.b_valid  = 1'b0;
    assign axi.b        = '0;
`endif

    // Next-state logic; AR has priority over AW in IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (ar_hs) state_n = BURST;
`ifdef IMEM_AXI_WR_ERR_EN
                else if (aw_hs) state_n = WDATA;
`endif
            end
            BURST: if (pop && f0.last) state_n = IDLE;
`ifdef IMEM_AXI_WR_ERR_EN
            WDATA: if (w_hs && axi.w.last) state_n = WRESP;
            WRESP: if (b_hs) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    // State register and idle-ready flag (ar_ready returns the cycle after the last R handshake).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_n;
            rdy_q <= (state_n == IDLE);
        end
    end

    // Burst context and address/beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q     <= '0;
            id_q      <= '0;
            fixed_q   <= 1'b0;
            err_req_q <= 1'b0;
            addr_q    <= '0;
            beat_cnt  <= '0;
        end else begin
            if (ar_hs) begin
                len_q     <= axi.ar.len;
                id_q      <= axi.ar.id;
                fixed_q   <= (axi.ar.burst == BURST_FIXED);
                err_req_q <= ar_err;
            end
            if (issue) begin
                addr_q   <= iss_fixed ? iss_addr : iss_addr + AXI_AW'(4);
                beat_cnt <= ar_hs ? (AXI_LW+1)'(1) : beat_cnt + (AXI_LW+1)'(1);
            end
        end
    end

    // SRAM request stage; error beats travel through it without strobing the SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            s1_v     <= 1'b0;
            s1_err   <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            mem_req <= issue && !iss_err;
            if (issue && !iss_err) mem_addr <= iss_addr[MEM_AW+1:2];
            s1_v    <= issue;
            s1_err  <= iss_err;
            s1_last <= iss_last;
        end
    end

    // Two-entry output FIFO: capture pending SRAM data, shift on pop, append from request stage.
    always_comb begin
        s1_ent.pend = !s1_err;
        s1_ent.last = s1_last;
        s1_ent.resp = s1_err ? RESP_SLVERR : RESP_OKAY;
        s1_ent.data = '0;
        f0_n  = f0;
        f1_n  = f1;
        cnt_n = cnt;
        if (f0.pend) begin
            f0_n.data = mem_rdata;
            f0_n.pend = 1'b0;
        end
        if (f1.pend) begin
            f1_n.data = mem_rdata;
            f1_n.pend = 1'b0;
        end
        if (pop) begin
            f0_n  = f1_n;
            f1_n  = '0;
            cnt_n = cnt_n - 2'd1;
        end
        if (s1_v) begin
            if (cnt_n == 2'd0) f0_n = s1_ent;
            else               f1_n = s1_ent;
            cnt_n = cnt_n + 2'd1;
        end
    end

    // Output FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f0        <= '0;
            f1        <= '0;
            cnt       <= '0;
            r_valid_q <= 1'b0;
        end else begin
            f0        <= f0_n;
            f1        <= f1_n;
            cnt       <= cnt_n;
            r_valid_q <= (cnt_n != 2'd0);
        end
    end

    assign axi.ar_ready = rdy_q;
    assign axi.r_valid  = r_valid_q;
    assign axi.r        = {id_q, (f0.pend ? mem_rdata : f0.data), f0.resp, f0.last};
endmodule

// File: tb/tb_intirvx_imem_axi_rd.sv
// Scoreboard bench for intirvx_imem_axi_rd; write-error checks follow IMEM_AXI_WR_ERR_EN.
module tb_intirvx_imem_axi_rd;
    import intirvx_imem_axi_rd_pkg::*;

    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned MEM_AW    = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    axi5 axi ();

    intirvx_imem_axi_rd #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axi      (axi),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: word w reads as 0xA500_0000 | w, garbage when not requested.
    always @(posedge clk) mem_rdata <= mem_req ? (32'hA500_0000 | 32'(mem_addr)) : 32'hDEAD_BEEF;

    int   checks = 0;
    int   failures = 0;
    r_t   exp_q[$];
    logic [MEM_AW-1:0] addr_q[$];
    int   issued = 0, popped_ok = 0, beats_seen = 0;
    bit   prev_stall = 0;
    r_t   prev_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // r_ready driver: held high, or the 1,0,0,1,0,1 pattern.
    bit       rr_mode = 0;
    logic [5:0] pat = 6'b101001;
    int       ph = 0;
    always @(posedge clk) begin
        #1;
        if (rr_mode) begin
            axi.r_ready = pat[ph];
            ph = (ph == 5) ? 0 : ph + 1;
        end else begin
            axi.r_ready = 1'b1;
            ph = 0;
        end
    end

    // Monitor: compares SRAM requests and R beats against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            issued = 0;
            popped_ok = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("r_hold_valid", 64'(axi.r_valid), 64'(1));
                chk("r_hold_payload", 64'(axi.r), 64'(prev_r));
            end
            if (mem_req) begin
                issued++;
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req: got addr %0h expected none at %0t", mem_addr, $time);
                end else begin
                    logic [MEM_AW-1:0] a;
                    a = addr_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(a));
                end
            end
            if (axi.r_valid && axi.r_ready) begin
                beats_seen++;
                if (axi.r.resp == RESP_OKAY) popped_ok++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_r_beat: got %0h expected none at %0t", axi.r, $time);
                end else begin
                    r_t e;
                    e = exp_q.pop_front();
                    chk("r_data", 64'(axi.r.data), 64'(e.data));
                    chk("r_resp", 64'(axi.r.resp), 64'(e.resp));
                    chk("r_last", 64'(axi.r.last), 64'(e.last));
                    chk("r_id",   64'(axi.r.id),   64'(e.id));
                end
            end
            if (mem_req) chk("outstanding_le2", 64'(issued - popped_ok <= 2), 64'(1));
            prev_stall = axi.r_valid && !axi.r_ready;
            prev_r     = axi.r;
        end
    end

    task automatic step_n();
        @(negedge clk);
        #1;
    endtask

    // Push the expected beats (and SRAM word addresses of OK beats) for one AR.
    task automatic expect_burst(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
        logic req_err;
        req_err = (size != SIZE_S32) || !((burst == BURST_FIXED) || (burst == BURST_INCR));
        for (int k = 0; k <= int'(len); k++) begin
            logic [31:0] a;
            logic        err;
            r_t          b;
            a   = (burst == BURST_FIXED) ? {addr[31:2], 2'b00} : {addr[31:2], 2'b00} + 32'(4 * k);
            err = req_err || (a >= 32'(MEM_WORDS * 4));
            if (!err) addr_q.push_back(a[13:2]);
            b.id   = id;
            b.data = err ? 32'h0 : (32'hA500_0000 | 32'(a[13:2]));
            b.resp = err ? RESP_SLVERR : RESP_OKAY;
            b.last = (k == int'(len));
            exp_q.push_back(b);
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
        @(posedge clk);
        #1;
        axi.ar_valid   = 1'b1;
        axi.ar.addr    = addr;
        axi.ar.len     = len;
        axi.ar.size    = size;
        axi.ar.burst   = burst;
        axi.ar.id      = id;
        for (int i = 0; i < 50; i++) begin
            step_n();
            if (axi.ar_ready) break;
        end
        chk("ar_accept", 64'(axi.ar_ready), 64'(1));
        @(posedge clk);
        #1;
        axi.ar_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && n < 3000) begin
            step_n();
            n++;
        end
        chk({name, "_drain"}, 64'(exp_q.size() + addr_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.ar_valid = 1'b0; axi.ar = '0;
        axi.aw_valid = 1'b0; axi.aw = '0;
        axi.w_valid  = 1'b0; axi.w  = '0;
        axi.b_ready  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        step_n();
        chk("rst_r_valid",  64'(axi.r_valid),  64'(0));
        chk("rst_ar_ready", 64'(axi.ar_ready), 64'(0));
        chk("rst_mem_req",  64'(mem_req),      64'(0));
        chk("rst_r_last",   64'(axi.r.last),   64'(0));
        chk("rst_r_resp",   64'(axi.r.resp),   64'(RESP_OKAY));
        chk("rst_r_data",   64'(axi.r.data),   64'(0));
        chk("rst_aw_ready", 64'(axi.aw_ready), 64'(0));
        chk("rst_w_ready",  64'(axi.w_ready),  64'(0));
        chk("rst_b_valid",  64'(axi.b_valid),  64'(0));
        rst_n = 1'b1;
        step_n();
        chk("idle_ar_ready", 64'(axi.ar_ready), 64'(1));

        // 0x100 len 7 INCR id 3: words 0x40..0x47, latency N+1 mem_req, N+2 r_valid.
        expect_burst(32'h100, 8'd7, SIZE_S32, BURST_INCR, 4'd3);
        send_ar(32'h100, 8'd7, SIZE_S32, BURST_INCR, 4'd3);
        step_n();
        chk("t1_mem_req_n1", 64'(mem_req), 64'(1));
        chk("t1_r_valid_n1", 64'(axi.r_valid), 64'(0));
        step_n();
        chk("t1_r_valid_n2", 64'(axi.r_valid), 64'(1));
        drain("t1");
        chk("t1_ar_ready_lastpop", 64'(axi.ar_ready), 64'(0));
        step_n();
        chk("t1_ar_ready_after", 64'(axi.ar_ready), 64'(1));

        // 0x20 len 3 FIXED: four copies of word 0x8, mem_addr 0x8 each time.
        expect_burst(32'h20, 8'd3, SIZE_S32, BURST_FIXED, 4'd1);
        send_ar(32'h20, 8'd3, SIZE_S32, BURST_FIXED, 4'd1);
        drain("t2");

        // Same as the first burst with r_ready toggling.
        rr_mode = 1;
        expect_burst(32'h100, 8'd7, SIZE_S32, BURST_INCR, 4'd3);
        send_ar(32'h100, 8'd7, SIZE_S32, BURST_INCR, 4'd3);
        drain("t3");
        rr_mode = 0;

        // 0x3FF8 len 3: words 0xFFE,0xFFF OK then two SLVERR beats.
        expect_burst(32'h3FF8, 8'd3, SIZE_S32, BURST_INCR, 4'd4);
        send_ar(32'h3FF8, 8'd3, SIZE_S32, BURST_INCR, 4'd4);
        drain("t4");

        // S16 len 1: two SLVERR beats, no SRAM access.
        expect_burst(32'h40, 8'd1, SIZE_S16, BURST_INCR, 4'd6);
        send_ar(32'h40, 8'd1, SIZE_S16, BURST_INCR, 4'd6);
        drain("t5");

        // len 0: single beat with last.
        expect_burst(32'h4, 8'd0, SIZE_S32, BURST_INCR, 4'd7);
        send_ar(32'h4, 8'd0, SIZE_S32, BURST_INCR, 4'd7);
        drain("t6");

        // len 255 from 0x3F00: 64 OK beats (0xFC0..0xFFF) then 192 SLVERR.
        expect_burst(32'h3F00, 8'd255, SIZE_S32, BURST_INCR, 4'd8);
        send_ar(32'h3F00, 8'd255, SIZE_S32, BURST_INCR, 4'd8);
        drain("t7");

        // Reset during beat 3 of a len 7 burst.
        begin
            int base;
            base = beats_seen;
            expect_burst(32'h0, 8'd7, SIZE_S32, BURST_INCR, 4'd9);
            send_ar(32'h0, 8'd7, SIZE_S32, BURST_INCR, 4'd9);
            for (int i = 0; i < 50; i++) begin
                if (beats_seen >= base + 2) break;
                step_n();
            end
            chk("t8_two_beats", 64'(beats_seen >= base + 2), 64'(1));
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            chk("t8_r_valid_in_rst", 64'(axi.r_valid), 64'(0));
            step_n();
            chk("t8_ar_ready_in_rst", 64'(axi.ar_ready), 64'(0));
            chk("t8_mem_req_in_rst",  64'(mem_req),      64'(0));
            rst_n = 1'b1;
            step_n();
            chk("t8_ar_ready_after", 64'(axi.ar_ready), 64'(1));
            chk("t8_r_valid_after",  64'(axi.r_valid),  64'(0));
            repeat (4) step_n();
        end

`ifdef IMEM_AXI_WR_ERR_EN
        // AW id 5 together with AR: AR wins, then 4 W beats and one SLVERR B.
        begin
            int nb;
            expect_burst(32'h10, 8'd0, SIZE_S32, BURST_INCR, 4'd2);
            @(posedge clk);
            #1;
            axi.ar_valid = 1'b1;
            axi.ar.addr = 32'h10; axi.ar.len = 8'd0; axi.ar.size = SIZE_S32;
            axi.ar.burst = BURST_INCR; axi.ar.id = 4'd2;
            axi.aw_valid = 1'b1;
            axi.aw.addr = 32'h80; axi.aw.len = 8'd3; axi.aw.size = SIZE_S32;
            axi.aw.burst = BURST_INCR; axi.aw.id = 4'd5;
            step_n();
            chk("wr_aw_blocked", 64'(axi.aw_ready), 64'(0));
            chk("wr_ar_first",   64'(axi.ar_ready), 64'(1));
            @(posedge clk);
            #1;
            axi.ar_valid = 1'b0;
            for (int i = 0; i < 50; i++) begin
                step_n();
                if (axi.aw_ready) break;
            end
            chk("wr_aw_accept", 64'(axi.aw_ready), 64'(1));
            chk("wr_read_done", 64'(exp_q.size()), 64'(0));
            @(posedge clk);
            #1;
            axi.aw_valid = 1'b0;
            for (int i = 0; i < 4; i++) begin
                axi.w_valid = 1'b1;
                axi.w.data  = 32'(i);
                axi.w.strb  = 4'hF;
                axi.w.last  = (i == 3);
                for (int j = 0; j < 20; j++) begin
                    step_n();
                    if (axi.w_ready) break;
                end
                chk("wr_w_ready", 64'(axi.w_ready), 64'(1));
                @(posedge clk);
                #1;
            end
            axi.w_valid = 1'b0;
            axi.w.last  = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step_n();
                if (axi.b_valid) break;
            end
            chk("wr_b_valid", 64'(axi.b_valid), 64'(1));
            chk("wr_b_id",    64'(axi.b.id),    64'(5));
            chk("wr_b_resp",  64'(axi.b.resp),  64'(RESP_SLVERR));
            step_n();
            chk("wr_b_hold",  64'(axi.b_valid), 64'(1));
            @(posedge clk);
            #1;
            axi.b_ready = 1'b1;
            @(posedge clk);
            #1;
            axi.b_ready = 1'b0;
            nb = 0;
            for (int i = 0; i < 6; i++) begin
                step_n();
                nb += int'(axi.b_valid);
            end
            chk("wr_single_b", 64'(nb), 64'(0));
            chk("wr_idle_ar_ready", 64'(axi.ar_ready), 64'(1));
        end
`else
        // Write channel disabled: AW/W ignored, no B.
        axi.aw_valid = 1'b1;
        axi.aw.id    = 4'd5;
        axi.w_valid  = 1'b1;
        axi.w.last   = 1'b1;
        axi.b_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_n();
            chk("nowr_aw_ready", 64'(axi.aw_ready), 64'(0));
            chk("nowr_w_ready",  64'(axi.w_ready),  64'(0));
            chk("nowr_b_valid",  64'(axi.b_valid),  64'(0));
        end
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        axi.b_ready  = 1'b0;
        chk("nowr_ar_ready", 64'(axi.ar_ready), 64'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/intirvx_imem_axi_rd.md
Name: intirvx_imem_axi_rd

Overview:
- AXI5 read responder (slave) fronting a synchronous-read instruction SRAM.
- Serves the fetch unit's INCR read bursts: accepts one AR at a time and returns len+1 R beats in order at up to 1 beat/cycle.
- Sits between the core's instruction AXI port and the SRAM macro; is the far end of the fetch master.

Parameters:
- MEM_WORDS, 4096, number of 32-bit words in the SRAM; byte range is [0, MEM_WORDS*4).
- MEM_AW, $clog2(MEM_WORDS), SRAM word-address width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- axi  interface  -  axi5.slave modport; AR, R, AW, W and B channels.
- mem_req  output  1  SRAM read strobe.
- mem_addr  output  MEM_AW  SRAM word address (byte address [MEM_AW+1:2]).
- mem_rdata  input  xlen  SRAM read data, valid exactly 1 cycle after mem_req.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All flops clear on rst_n low.
- Reset values: state=IDLE, ar_ready=0 while rst_n low, r_valid=0, r.last=0, r.resp=OKAY, r.data=0, mem_req=0, aw_ready=0, w_ready=0, b_valid=0.
- States:
  - IDLE: ar_ready=1. AR handshake latches addr (bits [1:0] ignored), len, id, and err_req = (size!=S32) or (burst not in {FIXED, INCR}). Sets beat_cnt=0 and goes to BURST.
  - BURST: issues beats while beat_cnt<=len and credit is available (at most 2 beats outstanding, counting SRAM in flight plus output buffer).
    - Beat address: FIXED holds the start address; INCR adds 4 per beat and wraps modulo 2^alen.
    - Beat error if err_req or address >= MEM_WORDS*4. Error beats do not assert mem_req, return data=0 and resp=SLVERR, and stay in order with OK beats.
    - OK beats assert mem_req for one cycle; rdata is captured into the 2-entry output FIFO the following cycle.
    - Go to IDLE on the R handshake of the beat with last=1.
- R channel:
  - r.id = latched id.
  - r.last=1 only on beat index len.
  - r_valid, once high, stays high with a stable payload until r_ready.
  - No bubbles when r_ready is held high: 1 beat/cycle.
- Latency:
  - First r_valid is 2 cycles after the AR handshake cycle (cycle N handshake, N+1 mem_req, N+2 r_valid).
  - ar_ready is reasserted the cycle after the last R handshake.
- Backpressure: with r_ready low, at most 2 beats are buffered and mem_req stalls. No data is lost and none is duplicated.
- len=0: single beat with last=1.
- len=255 INCR: 256 beats. The address counter is alen wide and wraps; an out-of-range address only produces SLVERR.
- Reset mid-burst: the burst is abandoned, no further R beats, IDLE after release.
- Only one burst is outstanding; AR is not accepted while in BURST.

Optional Feature:
- Macro IMEM_AXI_WR_ERR_EN.
- Defined:
  - Write channel handled as an error responder. AW is accepted in IDLE only, with priority to AR when both are valid.
  - W beats are consumed (w_ready=1) until w.last.
  - One B is returned with b.id = aw.id and resp=SLVERR; hold b_valid until b_ready, then return to IDLE.
  - SRAM is never written.
- Undefined: aw_ready=0, w_ready=0, b_valid=0 permanently; write-channel inputs are ignored.

Test Plan:
- AR addr=0x100, len=7, INCR, S32, id=3, r_ready=1 -> 8 beats on consecutive cycles.
  - Data = SRAM words 0x40..0x47, resp OKAY, id=3, last only on beat 8.
  - First r_valid 2 cycles after handshake.
- AR addr=0x20, len=3, FIXED -> 4 beats all equal to word 0x8; mem_addr constant.
- Same as the first case with r_ready toggling 1,0,0,1,0,1... -> all 8 words delivered once, in order.
  - Payload stable while stalled; never more than 2 mem_req ahead of the R handshakes.
- AR addr=MEM_WORDS*4-8, len=3, INCR -> beats 1-2 OKAY with SRAM data; beats 3-4 data=0, resp SLVERR, no mem_req; last on beat 4.
- AR size=S16, len=1 -> 2 SLVERR beats, zero mem_req.
  - Assert rst_n low during beat 3 of a len=7 burst -> r_valid=0 immediately, ar_ready=1 after release.
- IMEM_AXI_WR_ERR_EN defined: AW id=5 then 4 W beats with last on the 4th -> single B with id=5, SLVERR.
  - An AR presented simultaneously with the AW wins; the write is served afterwards.
